exe_stage_unit: RTL

- Execute-stage consumer of the decoded control bundle: exe_command, the memory read/write enables, write_back_enable, branch and status_out.
- Performs the ALU operation and owns the NZCV status register.
- Computes the branch target.
- Captures results into a valid/ready EX/MEM pipeline register that feeds the memory stage.

---
 rtl/exe_stage_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/exe_stage_unit.sv
// Execute stage: ALU, NZCV status register, branch target and
// the valid/ready EX/MEM register feeding the memory stage.
module exe_stage_unit #(
    parameter int WIDTH  = 32,
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        exe_command,
    input  logic              mem_read_enable,
    input  logic              mem_write_enable,
    input  logic              write_back_enable,
    input  logic              branch,
    input  logic              status_out,
    input  logic [WIDTH-1:0]  val_rn,
    input  logic [WIDTH-1:0]  val2,
    input  logic [WIDTH-1:0]  st_val,
    input  logic [DEST_W-1:0] dest,
    input  logic [WIDTH-1:0]  pc_in,
    input  logic [23:0]       imm24,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  alu_result,
    output logic [WIDTH-1:0]  st_val_out,
    output logic [DEST_W-1:0] dest_out,
    output logic              mem_read_out,
    output logic              mem_write_out,
    output logic              wb_en_out,
    output logic              branch_taken,
    output logic [WIDTH-1:0]  branch_addr,
    output logic [3:0]        status
);

    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_MVN = 4'b1001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SBC = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_ORR = 4'b0111;
    localparam logic [3:0] OP_EOR = 4'b1000;

    typedef struct packed {
        logic [WIDTH-1:0]  result;
        logic [WIDTH-1:0]  st_val;
        logic [DEST_W-1:0] dest;
        logic              mem_read;
        logic              mem_write;
        logic              wb_en;
        logic              branch;
        logic [WIDTH-1:0]  branch_addr;
    } ex_mem_t;

    ex_mem_t          q;
    logic             valid_q;
    logic [3:0]       nzcv_q;

    logic             accept;
    logic             cin;
    logic [WIDTH:0]   a_x;
    logic [WIDTH:0]   b_x;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             c_new;
    logic             v_new;
    logic             upd_cv;
    logic [3:0]       nzcv_next;
    logic [WIDTH-1:0] br_off;

    assign in_ready = rst_n && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready && !flush;

    assign cin = nzcv_q[1];
    assign a_x = {1'b0, val_rn};
    assign b_x = {1'b0, val2};

    // ALU result plus carry/overflow for arithmetic ops
    always_comb begin
        sum    = '0;
        res    = '0;
        c_new  = 1'b0;
        v_new  = 1'b0;
        upd_cv = 1'b0;
        unique case (1'b1)
            exe_command == OP_MOV: res = val2;
            exe_command == OP_MVN: res = ~val2;
            exe_command == OP_ADD,
            exe_command == OP_ADC: begin
                sum    = a_x + b_x
                       + {{WIDTH{1'b0}}, (exe_command == OP_ADC) && cin};
                res    = sum[WIDTH-1:0];
                upd_cv = 1'b1;
                c_new  = sum[WIDTH];
                v_new  = (val_rn[WIDTH-1] == val2[WIDTH-1])
                       && (res[WIDTH-1] != val_rn[WIDTH-1]);
            end
            exe_command == OP_SUB,
            exe_command == OP_SBC: begin
                sum    = a_x - b_x
                       - {{WIDTH{1'b0}}, (exe_command == OP_SBC) && !cin};
                res    = sum[WIDTH-1:0];
                upd_cv = 1'b1;
                c_new  = !sum[WIDTH];
                v_new  = (val_rn[WIDTH-1] != val2[WIDTH-1])
                       && (res[WIDTH-1] != val_rn[WIDTH-1]);
            end
            exe_command == OP_AND: res = val_rn & val2;
            exe_command == OP_ORR: res = val_rn | val2;
            exe_command == OP_EOR: res = val_rn ^ val2;
            default:               res = '0;
        endcase
    end

    // Logical ops keep the previous C and V
    always_comb begin
        nzcv_next = {res[WIDTH-1],
                     res == '0,
                     upd_cv ? c_new : nzcv_q[1],
                     upd_cv ? v_new : nzcv_q[0]};
    end

    assign br_off = {{(WIDTH-26){imm24[23]}}, imm24, 2'b00};

    // EX/MEM register and status: load on accept, drain or hold otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q       <= '0;
            valid_q <= 1'b0;
            nzcv_q  <= 4'b0000;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q       <= 1'b1;
            q.result      <= res;
            q.st_val      <= st_val;
            q.dest        <= dest;
            q.mem_read    <= mem_read_enable;
            q.mem_write   <= mem_write_enable;
            q.wb_en       <= write_back_enable;
            q.branch      <= branch;
            q.branch_addr <= pc_in + br_off;
            if (status_out) begin
                nzcv_q <= nzcv_next;
            end
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid     = valid_q;
    assign alu_result    = q.result;
    assign st_val_out    = q.st_val;
    assign dest_out      = q.dest;
    assign mem_read_out  = q.mem_read;
    assign mem_write_out = q.mem_write;
    assign wb_en_out     = q.wb_en;
    assign branch_taken  = q.branch && valid_q;
    assign branch_addr   = q.branch_addr;
    assign status        = nzcv_q;

endmodule
